sample_host: RTL and testbench
==============================

Name: sample_host

Overview:
- Host end of the SAMPLE/DONE statistics handshake: feeds 12-bit temperature samples (TN) to the averaging/std-dev engine and collects its 24-bit AVG_SD results.
- Buffers producer samples in a small FIFO and drives MODE per sample.
- Detects the engine's consume and result events, and returns tagged results on a valid/ready port.
- Sits between the sensor front-end and the result consumer, directly wired to the engine's TN/MODE/SAMPLE/DONE/AVG_SD pins.

Parameters:
- DEPTH, 8, sample FIFO entries (power of 2, ≥2)
- TIMEOUT, 1023, max clk cycles from consume (DONE rise) to result (DONE fall) before abort
- TW, 12, sample width
- RW, 24, result width

Ports:
- clk  in  1  clock
- RESET  in  1  reset, asynchronous, active-high
- s_data  in  TW  producer sample
- s_mode  in  1  mode tag for s_data (1 = std-dev, 0 = average)
- s_valid  in  1  producer valid
- s_ready  out  1  FIFO not full
- TN  out  TW  sample to engine
- MODE  out  1  mode to engine
- SAMPLE  in  1  engine requests sample
- DONE  in  1  engine busy/result flag
- AVG_SD  in  RW  engine result
- r_data  out  RW  captured result
- r_mode  out  1  mode the result was computed in
- r_valid  out  1  result valid
- r_ready  in  1  consumer ready
- underflow  out  1  sticky: engine consumed while FIFO empty
- overrun  out  1  sticky: result overwritten before r_ready
- timeout  out  1  sticky: DONE did not fall within TIMEOUT
- clr_flags  in  1  synchronous clear of sticky flags

Behaviour:
- Reset values:
  - TN=0, MODE=0, s_ready=1, r_data=0, r_mode=0, r_valid=0
  - all sticky flags 0, FIFO empty, state IDLE
- Edge detection:
  - Registered copies SAMPLE_q and DONE_q.
  - consume = DONE & ~DONE_q & ~SAMPLE.
  - result = ~DONE & DONE_q & SAMPLE.
- FIFO:
  - Push on s_valid & s_ready.
  - TN/MODE are driven from registers loaded with the FIFO head.
  - TN/MODE are stable whenever SAMPLE=1.
- FSM states:
  - IDLE:
    - Load TN/MODE from the head if not empty; go to ARMED.
    - Else hold the last TN/MODE and stay in IDLE.
  - ARMED:
    - Wait for consume.
    - On consume: pop the head if not empty, else set underflow (TN repeats the last value).
    - Latch pend_mode=MODE, clear the watchdog, go to BUSY.
  - BUSY:
    - Watchdog increments each cycle.
    - On result: r_data<=AVG_SD, r_mode<=pend_mode, r_valid<=1; if r_valid & ~r_ready that cycle, set overrun. Go to IDLE.
    - If watchdog==TIMEOUT: set timeout, go to IDLE, no result.
  - consume seen in IDLE is treated as in ARMED, using the held TN.
- Next-sample latency: TN/MODE for the next sample are valid 1 cycle after result, and within 1 cycle of the push if the FIFO was empty.
- Result port: r_valid clears on r_ready when no new result arrives that cycle; a new result wins over a simultaneous dequeue.
- Simultaneous push and pop: allowed; count unchanged; full FIFO with simultaneous pop accepts the push only if s_ready=1, and s_ready is registered from count.
- clr_flags and a simultaneous set: set wins.
- RESET mid-transaction: immediate return to reset values, FIFO flushed. The engine shares RESET, so the protocol restarts cleanly.
- Arithmetic: FIFO pointers are log2(DEPTH)+1 bits with wrap; the watchdog saturates at TIMEOUT.

Optional Feature:
- Macro: SAMPLE_HOST_THRESH_CMP_EN.
- Enabled:
  - Adds inputs thresh (RW) and alarm_clr (1), and output alarm (1).
  - On each captured result with r_mode=0, if AVG_SD > thresh then alarm<=1 and holds until alarm_clr.
  - Set beats a simultaneous clear.
  - alarm resets to 0.
- Disabled: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package sample_host_pkg holds:
  - state enum (IDLE, ARMED, BUSY)
  - default widths TW=12, RW=24
  - TIMEOUT default constant
- One sub-module, sample_fifo: sync FIFO with DEPTH/TW+1 width carrying {mode,data}, plus full/empty/count.

Test Plan:
- Push 14 samples (100..113, mode 0) with a behavioural engine model and r_ready=1 -> 14 results in order, r_mode=0, no flags; TN equals the pushed value during each SAMPLE=1 window.
- Push 5, mode 1, then hold r_ready=0 -> first result held, second result sets overrun, r_data is the second value.
- Empty FIFO and the engine asserts consume -> underflow=1, TN holds the last value (e.g. 113), a result is still captured; clr_flags clears underflow.
- Engine keeps DONE=1 for 1100 cycles with TIMEOUT=1023 -> timeout=1 at watchdog 1023, FSM back to IDLE, no r_valid.
- Assert RESET while in BUSY with 3 samples queued -> all outputs at reset values immediately; FIFO empty; s_ready=1.
- With SAMPLE_HOST_THRESH_CMP_EN and thresh=500, results 400 then 600 -> alarm rises after the 600 capture and stays until alarm_clr; a mode-1 result of 900 does not trigger alarm.

Source files
------------

// File: rtl/sample_host_pkg.sv
// sample_host_pkg
//   Shared types and default sizes for the sample_host block and its FIFO.
//   - state_e         : host FSM states (IDLE, ARMED, BUSY)
//   - TW_DEFAULT      : sample width (12)
//   - RW_DEFAULT      : result width (24)
//   - TIMEOUT_DEFAULT : consume-to-result watchdog limit in clk cycles (1023)
package sample_host_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BUSY  = 2'd2
  } state_e;

  localparam int TW_DEFAULT      = 12;
  localparam int RW_DEFAULT      = 24;
  localparam int TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/sample_host_fifo.sv
// sample_fifo
//   Synchronous FIFO holding {mode, sample} words for the engine.
//   Pointers carry one extra wrap bit so full and empty can be told apart.
//   Ports:
//     clk, RESET (async, active-high)
//     push, wr_data : write port, ignored while full
//     pop           : read advance, ignored while empty
//     rd_data       : current head word (combinational read)
//     full, empty   : occupancy status
//     count         : number of stored entries (0..DEPTH)
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 13
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/sample_host.sv
// sample_host
//   Host side of the SAMPLE/DONE statistics handshake. Producer samples are
//   queued in sample_fifo, presented to the engine on TN/MODE, and the
//   engine's AVG_SD results are returned on a valid/ready port tagged with
//   the mode they were computed in.
//   Ports:
//     clk, RESET (async, active-high)
//     s_data/s_mode/s_valid/s_ready : producer sample input
//     TN/MODE                       : sample and mode to engine
//     SAMPLE/DONE/AVG_SD            : engine handshake and result
//     r_data/r_mode/r_valid/r_ready : result output
//     underflow/overrun/timeout     : sticky error flags, cleared by clr_flags
//   Optional feature (macro SAMPLE_HOST_THRESH_CMP_EN):
//     thresh/alarm_clr/alarm : sticky alarm when an average result exceeds thresh
module sample_host
  import sample_host_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TW      = TW_DEFAULT,
  parameter int RW      = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic [TW-1:0] s_data,
  input  logic          s_mode,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [TW-1:0] TN,
  output logic          MODE,
  input  logic          SAMPLE,
  input  logic          DONE,
  input  logic [RW-1:0] AVG_SD,
  output logic [RW-1:0] r_data,
  output logic          r_mode,
  output logic          r_valid,
  input  logic          r_ready,
  output logic          underflow,
  output logic          overrun,
  output logic          timeout,
`ifdef SAMPLE_HOST_THRESH_CMP_EN
  input  logic [RW-1:0] thresh,
  input  logic          alarm_clr,
  output logic          alarm,
`endif
  input  logic          clr_flags
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [WDW-1:0] WD_MAX    = WDW'(TIMEOUT);

  state_e         state;
  state_e         state_next;
  logic           done_q;
  logic           consume;
  logic           result;
  logic           push;
  logic           pop;
  logic           take;
  logic           load_tn;
  logic           capture;
  logic           set_underflow;
  logic           set_overrun;
  logic           set_timeout;
  logic           wd_inc;
  logic [WDW-1:0] wd;
  logic           pend_mode;
  logic [TW:0]    fifo_rd;
  logic           fifo_full;
  logic           fifo_empty;
  logic [AW:0]    fifo_count;
  logic [AW:0]    count_after;

  // Engine events: consume is DONE rising while SAMPLE is low; result is
  // DONE falling together with SAMPLE requesting the next sample.
  assign consume = DONE & ~done_q & ~SAMPLE;
  assign result  = ~DONE & done_q & SAMPLE;

  assign push        = s_valid & s_ready & ~fifo_full;
  assign count_after = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (TW + 1)
  ) u_fifo (
    .clk     (clk),
    .RESET   (RESET),
    .push    (push),
    .wr_data ({s_mode, s_data}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A consume that arrives while still in IDLE is handled exactly like one
  // in ARMED: the engine has already taken the held TN.
  always_comb begin
    state_next    = state;
    take          = 1'b0;
    load_tn       = 1'b0;
    capture       = 1'b0;
    set_timeout   = 1'b0;
    wd_inc        = 1'b0;
    case (state)
      IDLE: begin
        if (consume) begin
          take       = 1'b1;
          state_next = BUSY;
        end else if (!fifo_empty) begin
          load_tn    = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (consume) begin
          take       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (result) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (wd == WD_MAX) begin
          set_timeout = 1'b1;
          state_next  = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    pop           = take & ~fifo_empty;
    set_underflow = take & fifo_empty;
    set_overrun   = capture & r_valid & ~r_ready;
  end

  // Datapath registers. s_ready is registered from the post-update count so
  // a full FIFO never accepts a push in the same cycle it pops.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      done_q    <= 1'b0;
      s_ready   <= 1'b1;
      TN        <= '0;
      MODE      <= 1'b0;
      pend_mode <= 1'b0;
      wd        <= '0;
      r_data    <= '0;
      r_mode    <= 1'b0;
      r_valid   <= 1'b0;
      underflow <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done_q  <= DONE;
      s_ready <= (count_after != DEPTH_CNT);
      if (load_tn) begin
        {MODE, TN} <= fifo_rd;
      end
      if (take) begin
        pend_mode <= MODE;
        wd        <= '0;
      end else if (wd_inc) begin
        wd <= wd + {{(WDW - 1){1'b0}}, 1'b1};
      end
      if (capture) begin
        r_data  <= AVG_SD;
        r_mode  <= pend_mode;
        r_valid <= 1'b1;
      end else if (r_ready) begin
        r_valid <= 1'b0;
      end
      underflow <= set_underflow | (underflow & ~clr_flags);
      overrun   <= set_overrun   | (overrun   & ~clr_flags);
      timeout   <= set_timeout   | (timeout   & ~clr_flags);
    end
  end

`ifdef SAMPLE_HOST_THRESH_CMP_EN
  // Only average-mode results are compared; a new trip beats alarm_clr.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      alarm <= 1'b0;
    end else begin
      alarm <= (capture & ~pend_mode & (AVG_SD > thresh)) | (alarm & ~alarm_clr);
    end
  end
`endif

endmodule

// File: tb/tb_sample_host.sv
// tb_sample_host
//   Directed bench for sample_host: streaming, underflow, overrun, watchdog
//   timeout, mid-transaction reset and (with SAMPLE_HOST_THRESH_CMP_EN) the
//   threshold alarm. The engine side is played by tasks in the main sequence.
module tb_sample_host;

  localparam int TW = 12;
  localparam int RW = 24;

  logic          clk = 1'b0;
  logic          RESET;
  logic [TW-1:0] s_data;
  logic          s_mode;
  logic          s_valid;
  logic          s_ready;
  logic [TW-1:0] TN;
  logic          MODE;
  logic          SAMPLE;
  logic          DONE;
  logic [RW-1:0] AVG_SD;
  logic [RW-1:0] r_data;
  logic          r_mode;
  logic          r_valid;
  logic          r_ready;
  logic          underflow;
  logic          overrun;
  logic          timeout;
  logic          clr_flags;
`ifdef SAMPLE_HOST_THRESH_CMP_EN
  logic [RW-1:0] thresh;
  logic          alarm_clr;
  logic          alarm;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_host dut (
    .clk       (clk),
    .RESET     (RESET),
    .s_data    (s_data),
    .s_mode    (s_mode),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .TN        (TN),
    .MODE      (MODE),
    .SAMPLE    (SAMPLE),
    .DONE      (DONE),
    .AVG_SD    (AVG_SD),
    .r_data    (r_data),
    .r_mode    (r_mode),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .underflow (underflow),
    .overrun   (overrun),
    .timeout   (timeout),
`ifdef SAMPLE_HOST_THRESH_CMP_EN
    .thresh    (thresh),
    .alarm_clr (alarm_clr),
    .alarm     (alarm),
`endif
    .clr_flags (clr_flags)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Producer push; returns at the negedge after the sample was accepted.
  task automatic applyStimulus(input logic [TW-1:0] data, input logic mode);
    int n = 0;
    s_data  = data;
    s_mode  = mode;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic engineConsume();
    SAMPLE = 1'b0;
    DONE   = 1'b1;
    @(negedge clk);
  endtask

  task automatic engineResult(input int latency, input logic [RW-1:0] value, input logic clr);
    repeat (latency) @(negedge clk);
    AVG_SD    = value;
    DONE      = 1'b0;
    SAMPLE    = 1'b1;
    clr_flags = clr;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic flagPulse();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic runSample(input int tn, input logic mode, input int value, input string tag);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_tn"}, 32'(TN), 32'(tn));
    checkOutput({tag, "_mode"}, 32'(MODE), 32'(mode));
    engineConsume();
    engineResult(2, RW'(value), 1'b0);
    checkOutput({tag, "_rvalid"}, 32'(r_valid), 32'd1);
    checkOutput({tag, "_rdata"}, 32'(r_data), 32'(value));
    checkOutput({tag, "_rmode"}, 32'(r_mode), 32'(mode));
  endtask

  initial begin
    RESET     = 1'b1;
    s_data    = '0;
    s_mode    = 1'b0;
    s_valid   = 1'b0;
    SAMPLE    = 1'b1;
    DONE      = 1'b0;
    AVG_SD    = '0;
    r_ready   = 1'b1;
    clr_flags = 1'b0;
`ifdef SAMPLE_HOST_THRESH_CMP_EN
    thresh    = RW'(500);
    alarm_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_tn", 32'(TN), 32'd0);
    checkOutput("rst_mode", 32'(MODE), 32'd0);
    checkOutput("rst_sready", 32'(s_ready), 32'd1);
    checkOutput("rst_rdata", 32'(r_data), 32'd0);
    checkOutput("rst_rvalid", 32'(r_valid), 32'd0);
    checkOutput("rst_flags", 32'({underflow, overrun, timeout}), 32'd0);

    $display("[TB] streaming 14 samples");
    for (int i = 0; i < 8; i++) applyStimulus(TW'(100 + i), 1'b0);
    checkOutput("full_sready", 32'(s_ready), 32'd0);
    for (int i = 0; i < 14; i++) begin
      runSample(100 + i, 1'b0, 1000 + i, $sformatf("s%0d", i));
      if (i < 6) applyStimulus(TW'(108 + i), 1'b0);
    end
    checkOutput("s_flags", 32'({underflow, overrun, timeout}), 32'd0);

    $display("[TB] underflow");
    repeat (2) @(negedge clk);
    engineConsume();
    checkOutput("uf_flag", 32'(underflow), 32'd1);
    checkOutput("uf_tn", 32'(TN), 32'd113);
    engineResult(2, RW'(2222), 1'b0);
    checkOutput("uf_rvalid", 32'(r_valid), 32'd1);
    checkOutput("uf_rdata", 32'(r_data), 32'd2222);
    checkOutput("uf_rmode", 32'(r_mode), 32'd0);
    flagPulse();
    checkOutput("uf_clr", 32'(underflow), 32'd0);

    $display("[TB] overrun");
    r_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(TW'(200 + i), 1'b1);
    runSample(200, 1'b1, 5000, "ov0");
    checkOutput("ov0_flag", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("ov1_tn", 32'(TN), 32'd201);
    engineConsume();
    engineResult(2, RW'(5001), 1'b1);
    checkOutput("ov1_flag", 32'(overrun), 32'd1);
    checkOutput("ov1_rdata", 32'(r_data), 32'd5001);
    checkOutput("ov1_rvalid", 32'(r_valid), 32'd1);
    r_ready = 1'b1;
    @(negedge clk);
    checkOutput("ov_drain", 32'(r_valid), 32'd0);
    flagPulse();
    checkOutput("ov_clr", 32'(overrun), 32'd0);
    for (int i = 2; i < 5; i++) runSample(200 + i, 1'b1, 5000 + i, $sformatf("ov%0d", i));

    $display("[TB] watchdog timeout");
    applyStimulus(TW'(300), 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("to_tn", 32'(TN), 32'd300);
    engineConsume();
    repeat (1023) @(negedge clk);
    checkOutput("to_early", 32'(timeout), 32'd0);
    @(negedge clk);
    checkOutput("to_flag", 32'(timeout), 32'd1);
    repeat (76) @(negedge clk);
    checkOutput("to_rvalid_hold", 32'(r_valid), 32'd0);
    DONE   = 1'b0;
    SAMPLE = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("to_rvalid_rel", 32'(r_valid), 32'd0);
    checkOutput("to_sticky", 32'(timeout), 32'd1);
    applyStimulus(TW'(301), 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("to_idle_tn", 32'(TN), 32'd301);
    flagPulse();
    checkOutput("to_clr", 32'(timeout), 32'd0);

    $display("[TB] reset in BUSY");
    for (int i = 0; i < 3; i++) applyStimulus(TW'(302 + i), 1'b0);
    engineConsume();
    @(negedge clk);
    #2 RESET = 1'b1;
    SAMPLE = 1'b1;
    DONE   = 1'b0;
    #1;
    checkOutput("mr_tn", 32'(TN), 32'd0);
    checkOutput("mr_mode", 32'(MODE), 32'd0);
    checkOutput("mr_sready", 32'(s_ready), 32'd1);
    checkOutput("mr_rdata", 32'(r_data), 32'd0);
    checkOutput("mr_rvalid", 32'(r_valid), 32'd0);
    @(negedge clk);
    RESET = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mr_empty_tn", 32'(TN), 32'd0);
    applyStimulus(TW'(55), 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("mr_new_tn", 32'(TN), 32'd55);

`ifdef SAMPLE_HOST_THRESH_CMP_EN
    $display("[TB] threshold alarm");
    applyStimulus(TW'(56), 1'b0);
    applyStimulus(TW'(57), 1'b1);
    runSample(55, 1'b0, 400, "al0");
    checkOutput("al0_alarm", 32'(alarm), 32'd0);
    runSample(56, 1'b0, 600, "al1");
    checkOutput("al1_alarm", 32'(alarm), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("al1_hold", 32'(alarm), 32'd1);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    checkOutput("al_clr", 32'(alarm), 32'd0);
    runSample(57, 1'b1, 900, "al2");
    checkOutput("al2_alarm", 32'(alarm), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
